// File: rtl/adj_edge_streamer.sv
// adj_edge_streamer
//   Sequences adjacency-list fetches for the path-counting datapath. A node
//   index is accepted from the control FSM, its {edge base, degree} entry is
//   read from the offset table, and the node's successor indices are then read
//   from the edge-list RAM and streamed out one per beat through a 2-entry
//   output FIFO. Each beat carries a down-counter of remaining edges, which
//   includes the current beat, so the last beat carries 1.
//
// State table:
//   IDLE     | waiting for a request; accepts one only once the output FIFO is empty
//   OFF_WAIT | offset-table data valid; first edge read issued straight from it
//   STREAM   | issuing the remaining edge reads under FIFO credit
//   DRAIN    | all reads issued; waiting for the FIFO to empty
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake, req_node_idx = node to expand
//   flush                         synchronous abort of the current stream
//   off_rd_en/addr/data           offset-table port, data = {base, degree}, 1-cycle latency
//   edge_rd_en/addr/data          edge-list port, data = successor index, 1-cycle latency
//   next_node_valid/ready         output beat handshake
//   next_node_idx/counter/none    beat payload
//   busy                          not IDLE or output FIFO non-empty
module adj_edge_streamer #(
    parameter int NODE_IDX_WIDTH  = 10,
    parameter int COUNTER_WIDTH   = 4,
    parameter int EDGE_ADDR_WIDTH = 12
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     req_valid,
    input  logic [NODE_IDX_WIDTH-1:0]                req_node_idx,
    output logic                                     req_ready,
    input  logic                                     flush,
    output logic                                     off_rd_en,
    output logic [NODE_IDX_WIDTH-1:0]                off_rd_addr,
    input  logic [EDGE_ADDR_WIDTH+COUNTER_WIDTH-1:0] off_rd_data,
    output logic                                     edge_rd_en,
    output logic [EDGE_ADDR_WIDTH-1:0]               edge_rd_addr,
    input  logic [NODE_IDX_WIDTH-1:0]                edge_rd_data,
    output logic                                     next_node_valid,
    input  logic                                     next_node_ready,
    output logic [NODE_IDX_WIDTH-1:0]                next_node_idx,
    output logic [COUNTER_WIDTH-1:0]                 next_node_counter,
    output logic                                     next_node_none,
    output logic                                     busy
);

    localparam logic [COUNTER_WIDTH-1:0]   CNT_ONE = 1;
    localparam logic [EDGE_ADDR_WIDTH-1:0] EA_ONE  = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFF_WAIT = 2'd1,
        STREAM   = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [EDGE_ADDR_WIDTH-1:0] rd_addr;
    logic [COUNTER_WIDTH-1:0]   issue_left;
    logic [COUNTER_WIDTH-1:0]   remaining;
    logic                       rd_inflight;
    logic [1:0]                 occ;

    logic [NODE_IDX_WIDTH-1:0]  head_idx, tail_idx;
    logic [COUNTER_WIDTH-1:0]   head_cnt, tail_cnt;
    logic                       head_none, tail_none;

    logic [EDGE_ADDR_WIDTH-1:0] off_base;
    logic [COUNTER_WIDTH-1:0]   off_deg;
    logic                       pop;
    logic                       push;
    logic [NODE_IDX_WIDTH-1:0]  push_idx;
    logic [COUNTER_WIDTH-1:0]   push_cnt;
    logic [2:0]                 credit_used;
    logic                       room;
    logic [1:0]                 occ_after_pop;
    logic                       load_off;
    logic                       push_none;
    logic                       stream_issue;

    assign off_base = off_rd_data[EDGE_ADDR_WIDTH+COUNTER_WIDTH-1:COUNTER_WIDTH];
    assign off_deg  = off_rd_data[COUNTER_WIDTH-1:0];

    assign next_node_valid   = (occ != 2'd0);
    assign next_node_idx     = head_idx;
    assign next_node_counter = head_cnt;
    assign next_node_none    = head_none;
    assign busy              = (state != IDLE) || (occ != 2'd0);

    assign pop           = next_node_valid && next_node_ready;
    assign occ_after_pop = occ - {1'b0, pop};

    // A slot freed by a same-cycle pop is counted as available; without that
    // the stream would stall every other cycle with ready held high.
    assign credit_used = {1'b0, occ} + {2'b00, rd_inflight} - {2'b00, pop};
    assign room        = (credit_used < 3'd2);

    assign push     = push_none || rd_inflight;
    assign push_idx = push_none ? '0 : edge_rd_data;
    assign push_cnt = push_none ? '0 : remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        off_rd_en    = 1'b0;
        off_rd_addr  = '0;
        edge_rd_en   = 1'b0;
        edge_rd_addr = '0;
        load_off     = 1'b0;
        push_none    = 1'b0;
        stream_issue = 1'b0;
        case (state)
            IDLE: begin
                req_ready = (occ == 2'd0);
                if (req_valid && req_ready) begin
                    off_rd_en   = 1'b1;
                    off_rd_addr = req_node_idx;
                    state_nxt   = OFF_WAIT;
                end
            end
            OFF_WAIT: begin
                // FIFO is guaranteed empty here, so the first read needs no credit check.
                load_off = 1'b1;
                if (off_deg == '0) begin
                    push_none = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    edge_rd_en   = 1'b1;
                    edge_rd_addr = off_base;
                    state_nxt    = (off_deg == CNT_ONE) ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (room && (issue_left != '0)) begin
                    edge_rd_en   = 1'b1;
                    edge_rd_addr = rd_addr;
                    stream_issue = 1'b1;
                    if (issue_left == CNT_ONE) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!rd_inflight && (occ_after_pop == 2'd0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (flush) begin
            state_nxt    = IDLE;
            req_ready    = 1'b0;
            off_rd_en    = 1'b0;
            off_rd_addr  = '0;
            edge_rd_en   = 1'b0;
            edge_rd_addr = '0;
            load_off     = 1'b0;
            push_none    = 1'b0;
            stream_issue = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr     <= '0;
            issue_left  <= '0;
            remaining   <= '0;
            rd_inflight <= 1'b0;
            occ         <= 2'd0;
            head_idx    <= '0;
            head_cnt    <= '0;
            head_none   <= 1'b0;
            tail_idx    <= '0;
            tail_cnt    <= '0;
            tail_none   <= 1'b0;
        end else if (flush) begin
            // Clearing rd_inflight drops any read data returning next cycle.
            rd_addr     <= '0;
            issue_left  <= '0;
            remaining   <= '0;
            rd_inflight <= 1'b0;
            occ         <= 2'd0;
            head_idx    <= '0;
            head_cnt    <= '0;
            head_none   <= 1'b0;
            tail_idx    <= '0;
            tail_cnt    <= '0;
            tail_none   <= 1'b0;
        end else begin
            rd_inflight <= edge_rd_en;

            if (load_off) begin
                remaining  <= off_deg;
                issue_left <= (off_deg == '0) ? '0 : off_deg - CNT_ONE;
                rd_addr    <= off_base + EA_ONE;
            end else begin
                if (stream_issue) begin
                    issue_left <= issue_left - CNT_ONE;
                    rd_addr    <= rd_addr + EA_ONE;
                end
                if (rd_inflight) begin
                    remaining <= remaining - CNT_ONE;
                end
            end

            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_idx  <= push_idx;
                        head_cnt  <= push_cnt;
                        head_none <= push_none;
                        occ       <= 2'd1;
                    end else begin
                        tail_idx  <= push_idx;
                        tail_cnt  <= push_cnt;
                        tail_none <= push_none;
                        occ       <= 2'd2;
                    end
                end
                2'b01: begin
                    if (occ == 2'd2) begin
                        head_idx  <= tail_idx;
                        head_cnt  <= tail_cnt;
                        head_none <= tail_none;
                    end
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_idx  <= push_idx;
                        head_cnt  <= push_cnt;
                        head_none <= push_none;
                    end else begin
                        head_idx  <= tail_idx;
                        head_cnt  <= tail_cnt;
                        head_none <= tail_none;
                        tail_idx  <= push_idx;
                        tail_cnt  <= push_cnt;
                        tail_none <= push_none;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
